pipelined_rbs: RTL

PIPELINED_RBS -- requirements
Module: pipelined_rbs

---
 rtl/pipelined_rbs_pkg.sv | 16 +
 rtl/pipelined_rbs_if.sv | 38 +++
 rtl/full_subtractor.sv | 13 +
 rtl/pipelined_rbs.sv | 98 +++++++++
 4 files changed

// File: rtl/pipelined_rbs_pkg.sv
// Shared constants and the per-stage register layout for the pipelined ripple-borrow subtractor.
package pipelined_rbs_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int WIDTH_MAX     = 32;

  // Data fields are sized for the widest build; a WIDTH-bit instance uses bits [WIDTH-1:0].
  typedef struct packed {
    logic                 valid;
    logic                 borrow;
    logic [WIDTH_MAX-1:0] diff;
    logic [WIDTH_MAX-1:0] a;
    logic [WIDTH_MAX-1:0] b;
  } stage_t;

endpackage

// File: rtl/pipelined_rbs_if.sv
// Operand/result handshake bundle for pipelined_rbs.
// Zero/Overflow exist only when PIPELINED_RBS_FLAGS_EN is defined.
interface pipelined_rbs_if
  import pipelined_rbs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             out_valid;
  logic             out_ready;
`ifdef PIPELINED_RBS_FLAGS_EN
  logic             Zero;
  logic             Overflow;
`endif

  modport master (
    output A, B, Bin, in_valid, out_ready,
    input  in_ready, Diff, Bout, out_valid
`ifdef PIPELINED_RBS_FLAGS_EN
    , input Zero, Overflow
`endif
  );

  modport slave (
    input  A, B, Bin, in_valid, out_ready,
    output in_ready, Diff, Bout, out_valid
`ifdef PIPELINED_RBS_FLAGS_EN
    , output Zero, Overflow
`endif
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when a borrow is needed.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/pipelined_rbs.sv
// Ripple-borrow subtractor pipelined one bit per stage with a global stall (advance) signal.
// Optional Zero/Overflow flags are enabled by defining PIPELINED_RBS_FLAGS_EN.
module pipelined_rbs
  import pipelined_rbs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic           Clock,
  input logic           Reset,
  pipelined_rbs_if.slave bus
);

  stage_t stage_reg  [WIDTH];
  stage_t stage_next [WIDTH];
  logic   advance;

  // The whole pipe moves in lockstep; only a parked, unconsumed result can stall it.
  assign advance      = !stage_reg[WIDTH-1].valid || bus.out_ready;
  assign bus.in_ready = advance;

`ifdef PIPELINED_RBS_FLAGS_EN
  logic [WIDTH-1:0] borrow_in;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    stage_t src;
    stage_t nxt;
    logic   d_bit;
    logic   bout_bit;

    if (gi == 0) begin : g_head
      always_comb begin
        src              = '0;
        src.valid        = bus.in_valid;
        src.borrow       = bus.Bin;
        src.a[WIDTH-1:0] = bus.A;
        src.b[WIDTH-1:0] = bus.B;
      end
    end else begin : g_body
      assign src = stage_reg[gi-1];
    end

    full_subtractor u_fs (
      .a    (src.a[gi]),
      .b    (src.b[gi]),
      .bin  (src.borrow),
      .d    (d_bit),
      .bout (bout_bit)
    );

    // Operand bits are cleared once consumed so each register holds only pending bits.
    always_comb begin
      nxt          = src;
      nxt.diff[gi] = d_bit;
      nxt.borrow   = bout_bit;
      nxt.a[gi]    = 1'b0;
      nxt.b[gi]    = 1'b0;
    end

    assign stage_next[gi] = nxt;

`ifdef PIPELINED_RBS_FLAGS_EN
    assign borrow_in[gi] = src.borrow;
`endif
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < WIDTH; i++) stage_reg[i] <= '0;
    end else if (advance) begin
      for (int i = 0; i < WIDTH; i++) stage_reg[i] <= stage_next[i];
    end
  end

  assign bus.Diff      = stage_reg[WIDTH-1].diff[WIDTH-1:0];
  assign bus.Bout      = stage_reg[WIDTH-1].borrow;
  assign bus.out_valid = stage_reg[WIDTH-1].valid;

`ifdef PIPELINED_RBS_FLAGS_EN
  logic zero_reg;
  logic overflow_reg;

  // Signed overflow: borrow into the sign bit differs from borrow out of it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      zero_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (advance) begin
      zero_reg     <= (stage_next[WIDTH-1].diff[WIDTH-1:0] == '0);
      overflow_reg <= borrow_in[WIDTH-1] ^ stage_next[WIDTH-1].borrow;
    end
  end

  assign bus.Zero     = zero_reg;
  assign bus.Overflow = overflow_reg;
`endif

endmodule
